eth_measurer_scheduler: RTL and testbench
=========================================

// Module: eth_measurer_scheduler
// PURPOSE
//  Sequences ping probes for the Ethernet latency measurer: issues one TX request per period, tracks the echo
//  returned through the loopback path, and reports round-trip latency or loss per probe.
//  Sits between the AXI register bank (enable/period/timeout) and the frame TX generator / RX echo parser,
//  in the main-interface clock domain, timestamped by the shared 64-bit timer.
// PARAMETERS
//  cnt_width  32  width of period, timeout and their internal cycle counters
// PORTS
//  clk             in   1          main-interface clock
//  rst             in   1          synchronous, active-high reset
//  enable          in   1          level; 1 = run probe sequence
//  period          in   cnt_width  cycles between successive TX handshakes (0 treated as 1)
//  timeout         in   cnt_width  cycles after TX handshake before probe declared lost (0 treated as 1)
//  current_time    in   64         shared timer value
//  time_running    in   1          timer running; all internal counters freeze while 0
//  tx_req          out  1          request TX generator to send probe
//  tx_seq          out  32         sequence number to embed in probe
//  tx_ack          in   1          TX generator accepted request (handshake = tx_req & tx_ack)
//  rx_valid        in   1          1-cycle pulse: echo frame parsed
//  rx_seq          in   32         sequence number of echo
//  rx_time         in   64         timestamp of echo arrival
//  result_valid    out  1          1-cycle pulse: probe completed
//  result_lost     out  1          qualifies result_valid: 1 = timeout, 0 = echo received
//  result_seq      out  32         sequence number of completed probe
//  result_latency  out  64         rx_time - tx timestamp; 0 when lost
//  ping_count      out  64         echoes received since reset
//  lost_count      out  64         timeouts since reset
//  busy            out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, every output 0, tx_seq=0, internal counters 0. Mid-operation reset aborts the probe with no result.
//  FSM (registered outputs, transitions on rising clk):
//   IDLE: enable & time_running -> SEND.
//   SEND: tx_req=1, tx_seq held stable. Handshake -> latch t_tx=current_time, clear period_cnt and
//     timeout_cnt -> WAIT_ECHO; tx_req drops the cycle after handshake. enable=0 before handshake -> IDLE, no result.
//   WAIT_ECHO: rx_valid & rx_seq==tx_seq -> result_valid=1, result_lost=0,
//     result_latency=rx_time-t_tx (64-bit modulo 2^64), ping_count+1 -> WAIT_PERIOD.
//     rx_valid with mismatched seq: ignored. timeout_cnt reaches max(timeout,1)-1 with no match -> result_valid=1,
//     result_lost=1, result_latency=0, lost_count+1 -> WAIT_PERIOD. Match and timeout on same cycle: match wins.
//     enable=0 here does not abort; probe finishes first.
//   WAIT_PERIOD: when period_cnt >= max(period,1)-1 -> (enable ? SEND : IDLE). Counter already expired -> leave next cycle.
//  period_cnt and timeout_cnt both run from the TX handshake, +1 per cycle with time_running=1, saturating.
//  tx_seq increments by 1 on leaving WAIT_ECHO; wraps 0xFFFFFFFF -> 0. result_seq = tx_seq of finished probe.
//  result_* fields hold until next result_valid. ping_count/lost_count wrap at 2^64.
//  Latency: handshake -> result_valid = 1 cycle after qualifying rx_valid / timeout.
// CONFIGURATION
//  ETH_MEASURER_SCHED_STATS_EN defined: extra outputs lat_min [63:0] (reset 0xFFFF_FFFF_FFFF_FFFF) and
//   lat_max [63:0] (reset 0), updated same cycle as result_valid for non-lost results.
//  Undefined: ports absent, no comparators synthesised; all other behaviour identical.
// TESTING
//  1. period=100, timeout=50, tx_ack tied 1, echo seq 0 at rx_time=t_tx+37 -> result_lost=0, latency=37, ping_count=1; next tx_req 100 cycles after first handshake.
//  2. No echo, timeout=50 -> result_valid with result_lost=1 exactly 50 cycles after handshake, lost_count=1, tx_seq=1.
//  3. Echo seq 5 while tx_seq=6, then seq 6 -> first ignored, second reported; echo matching on timeout cycle -> lost_count unchanged.
//  4. tx_seq preset by 0xFFFFFFFF probes (force) -> after completion tx_seq=0; current_time wrap between tx/rx -> correct modulo latency.
//  5. enable=0 during SEND with tx_ack=0 -> IDLE, no result; enable=0 in WAIT_ECHO -> result emitted, then IDLE; time_running=0 -> counters frozen.
//  6. STATS_EN: latencies 40, 12, 90 -> lat_min=12, lat_max=90; lost probe leaves both unchanged; rst mid-WAIT_ECHO -> all outputs 0.

Source files
------------

// File: rtl/eth_measurer_scheduler.sv
// Ping-probe sequencer for the Ethernet latency measurer: one TX request per period, echo tracking, latency/loss reporting.
// Optional min/max latency statistics are built when ETH_MEASURER_SCHED_STATS_EN is defined.
module eth_measurer_scheduler #(
    parameter int cnt_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [cnt_width-1:0] period,
    input  logic [cnt_width-1:0] timeout,
    input  logic [63:0]          current_time,
    input  logic                 time_running,
    output logic                 tx_req,
    output logic [31:0]          tx_seq,
    input  logic                 tx_ack,
    input  logic                 rx_valid,
    input  logic [31:0]          rx_seq,
    input  logic [63:0]          rx_time,
    output logic                 result_valid,
    output logic                 result_lost,
    output logic [31:0]          result_seq,
    output logic [63:0]          result_latency,
    output logic [63:0]          ping_count,
    output logic [63:0]          lost_count,
    output logic                 busy
`ifdef ETH_MEASURER_SCHED_STATS_EN
    ,
    output logic [63:0]          lat_min,
    output logic [63:0]          lat_max
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ECHO,
        WAIT_PERIOD
    } state_t;

    localparam logic [cnt_width-1:0] cnt_one = 1;
    localparam logic [cnt_width-1:0] cnt_max = '1;

    state_t               state;
    state_t               state_next;
    logic [cnt_width-1:0] period_cnt;
    logic [cnt_width-1:0] timeout_cnt;
    logic [cnt_width-1:0] period_lim;
    logic [cnt_width-1:0] timeout_lim;
    logic [63:0]          t_tx;
    logic [63:0]          echo_latency;
    logic                 handshake;
    logic                 echo_match;
    logic                 timed_out;
    logic                 period_done;

    // A programmed value of 0 behaves like 1, so the limit never underflows.
    assign period_lim   = (period == '0) ? '0 : period - cnt_one;
    assign timeout_lim  = (timeout == '0) ? '0 : timeout - cnt_one;

    assign handshake    = tx_req & tx_ack;
    assign echo_match   = rx_valid && (rx_seq == tx_seq);
    assign timed_out    = timeout_cnt >= timeout_lim;
    assign period_done  = period_cnt >= period_lim;
    assign echo_latency = rx_time - t_tx;

    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (enable && time_running) state_next = SEND;
            SEND: begin
                if (handshake)     state_next = WAIT_ECHO;
                else if (!enable)  state_next = IDLE;
            end
            WAIT_ECHO:   if (echo_match || timed_out) state_next = WAIT_PERIOD;
            WAIT_PERIOD: if (period_done) state_next = enable ? SEND : IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            tx_req         <= 1'b0;
            tx_seq         <= 32'd0;
            busy           <= 1'b0;
            period_cnt     <= '0;
            timeout_cnt    <= '0;
            t_tx           <= 64'd0;
            result_valid   <= 1'b0;
            result_lost    <= 1'b0;
            result_seq     <= 32'd0;
            result_latency <= 64'd0;
            ping_count     <= 64'd0;
            lost_count     <= 64'd0;
`ifdef ETH_MEASURER_SCHED_STATS_EN
            lat_min        <= '1;
            lat_max        <= 64'd0;
`endif
        end else begin
            state        <= state_next;
            tx_req       <= (state_next == SEND);
            busy         <= (state_next != IDLE);
            result_valid <= 1'b0;

            if (handshake) begin
                t_tx        <= current_time;
                period_cnt  <= '0;
                timeout_cnt <= '0;
            end else if (time_running) begin
                if (period_cnt != cnt_max)  period_cnt  <= period_cnt + cnt_one;
                if (timeout_cnt != cnt_max) timeout_cnt <= timeout_cnt + cnt_one;
            end

            // A matching echo takes priority over a timeout landing on the same cycle.
            if (state == WAIT_ECHO && (echo_match || timed_out)) begin
                result_valid   <= 1'b1;
                result_seq     <= tx_seq;
                tx_seq         <= tx_seq + 32'd1;
                if (echo_match) begin
                    result_lost    <= 1'b0;
                    result_latency <= echo_latency;
                    ping_count     <= ping_count + 64'd1;
`ifdef ETH_MEASURER_SCHED_STATS_EN
                    if (echo_latency < lat_min) lat_min <= echo_latency;
                    if (echo_latency > lat_max) lat_max <= echo_latency;
`endif
                end else begin
                    result_lost    <= 1'b1;
                    result_latency <= 64'd0;
                    lost_count     <= lost_count + 64'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_measurer_scheduler.sv
// Directed, scoreboard-based bench for eth_measurer_scheduler; define ETH_MEASURER_SCHED_STATS_EN to also check lat_min/lat_max.
module tb_eth_measurer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] period;
    logic [31:0] timeout;
    logic [63:0] current_time;
    logic        time_running;
    logic        tx_req;
    logic [31:0] tx_seq;
    logic        tx_ack;
    logic        rx_valid;
    logic [31:0] rx_seq;
    logic [63:0] rx_time;
    logic        result_valid;
    logic        result_lost;
    logic [31:0] result_seq;
    logic [63:0] result_latency;
    logic [63:0] ping_count;
    logic [63:0] lost_count;
    logic        busy;
`ifdef ETH_MEASURER_SCHED_STATS_EN
    logic [63:0] lat_min;
    logic [63:0] lat_max;
`endif

    always #5 clk = ~clk;

    eth_measurer_scheduler #(.cnt_width(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .timeout(timeout),
        .current_time(current_time), .time_running(time_running),
        .tx_req(tx_req), .tx_seq(tx_seq), .tx_ack(tx_ack),
        .rx_valid(rx_valid), .rx_seq(rx_seq), .rx_time(rx_time),
        .result_valid(result_valid), .result_lost(result_lost), .result_seq(result_seq),
        .result_latency(result_latency), .ping_count(ping_count), .lost_count(lost_count),
        .busy(busy)
`ifdef ETH_MEASURER_SCHED_STATS_EN
        , .lat_min(lat_min), .lat_max(lat_max)
`endif
    );

    typedef struct {
        logic        lost;
        logic [31:0] seq;
        logic [63:0] lat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    int          seen_results = 0;
    int          popped = 0;
    int          cyc = 0;
    bit          hs_last = 1'b0;
    logic [63:0] t_tx_model = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: note handshake/time before the edge, sample outputs 1 time unit after it.
    task automatic step();
        bit hs;
        bit tr;
        hs = tx_req && tx_ack && !rst;
        tr = time_running;
        if (hs) t_tx_model = current_time;
        @(posedge clk);
        #1;
        if (tr) current_time = current_time + 64'd1;
        hs_last = hs;
        if (hs) cyc = 0;
        else if (tr) cyc++;
        if (result_valid) seen_results++;
    endtask

    task automatic wait_hs(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!hs_last && n < budget);
        check(tag, hs_last, 1'b1);
    endtask

    task automatic wait_tx_req(input string tag, input int budget, input int exp_cyc);
        int n = 0;
        while (!tx_req && n < budget) begin
            step();
            n++;
        end
        check({tag, "_req"}, tx_req, 1'b1);
        check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic push(input logic lost, input logic [31:0] seq, input logic [63:0] lat, input int c);
        exp_t e;
        e.lost = lost;
        e.seq  = seq;
        e.lat  = lat;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Echo arriving at cycle at_cyc after the handshake, timestamped t_tx + at_cyc.
    task automatic probe_echo(input logic [31:0] seq, input int at_cyc);
        int n = 0;
        while (cyc < at_cyc - 1 && n < 1000) begin
            step();
            n++;
        end
        rx_valid = 1'b1;
        rx_seq   = seq;
        rx_time  = t_tx_model + 64'(at_cyc);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int budget);
        exp_t e;
        int   n = 0;
        while (!result_valid && n < budget) begin
            step();
            n++;
        end
        check({tag, "_valid"}, result_valid, 1'b1);
        if (result_valid) begin
            check({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                check({tag, "_lost"}, result_lost, e.lost);
                check({tag, "_seq"}, result_seq, e.seq);
                check({tag, "_lat"}, result_latency, e.lat);
                check({tag, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_req"}, tx_req, 1'b0);
        check({tag, "_tx_seq"}, tx_seq, 32'd0);
        check({tag, "_rvalid"}, result_valid, 1'b0);
        check({tag, "_rlost"}, result_lost, 1'b0);
        check({tag, "_rseq"}, result_seq, 32'd0);
        check({tag, "_rlat"}, result_latency, 64'd0);
        check({tag, "_ping"}, ping_count, 64'd0);
        check({tag, "_lost"}, lost_count, 64'd0);
        check({tag, "_busy"}, busy, 1'b0);
`ifdef ETH_MEASURER_SCHED_STATS_EN
        check({tag, "_lat_min"}, lat_min, 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_lat_max"}, lat_max, 64'd0);
`endif
    endtask

    initial begin
        int n0;
        int lats[3] = '{40, 12, 90};

        rst = 1'b1; enable = 1'b0; period = 32'd100; timeout = 32'd50;
        current_time = 64'd1000; time_running = 1'b1; tx_ack = 1'b1;
        rx_valid = 1'b0; rx_seq = 32'd0; rx_time = 64'd0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        // Probe 0: echo after 37 cycles, next request 100 cycles after handshake.
        enable = 1'b1;
        wait_hs("hs0", 10);
        push(1'b0, 32'd0, 64'd37, 37);
        probe_echo(32'd0, 37);
        expect_result("p0", 5);
        check("p0_ping", ping_count, 64'd1);
        wait_tx_req("p0_period", 200, 100);

        // Probe 1: no echo, lost after exactly 50 cycles.
        wait_hs("hs1", 5);
        push(1'b1, 32'd1, 64'd0, 50);
        expect_result("p1", 60);
        check("p1_lost_cnt", lost_count, 64'd1);
        check("p1_tx_seq", tx_seq, 32'd2);

        // Probe 2: stale sequence ignored, correct one reported.
        wait_hs("hs2", 200);
        probe_echo(32'd1, 10);
        push(1'b0, 32'd2, 64'd20, 20);
        probe_echo(32'd2, 20);
        expect_result("p2", 5);

        // Probe 3: echo on the timeout cycle wins over loss.
        wait_hs("hs3", 200);
        push(1'b0, 32'd3, 64'd50, 50);
        probe_echo(32'd3, 50);
        expect_result("p3", 5);
        check("p3_ping", ping_count, 64'd3);
        check("p3_lost_cnt", lost_count, 64'd1);

        enable = 1'b0;
        wait_idle("idle_after_p3", 200);
        check("p3_tx_seq", tx_seq, 32'd4);

        // Sequence-number wrap and timer wrap between TX and RX.
        force dut.tx_seq = 32'hFFFF_FFFF;
        step();
        release dut.tx_seq;
        step();
        check("preset_seq", tx_seq, 32'hFFFF_FFFF);
        current_time = 64'hFFFF_FFFF_FFFF_FFF6;
        enable = 1'b1;
        wait_hs("hs_wrap", 10);
        push(1'b0, 32'hFFFF_FFFF, 64'd25, 25);
        probe_echo(32'hFFFF_FFFF, 25);
        expect_result("pwrap", 5);
        check("wrap_tx_seq", tx_seq, 32'd0);

        // Disable while waiting for tx_ack aborts without a result.
        tx_ack = 1'b0;
        wait_tx_req("abort", 200, 100);
        n0 = seen_results;
        enable = 1'b0;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_tx_req", tx_req, 1'b0);
        repeat (3) step();
        check("abort_no_result", 64'(seen_results - n0), 64'd0);

        // Disable during WAIT_ECHO lets the probe finish, then idles.
        enable = 1'b1;
        tx_ack = 1'b1;
        wait_hs("hs_dis", 10);
        repeat (5) step();
        enable = 1'b0;
        repeat (5) step();
        check("dis_busy", busy, 1'b1);
        push(1'b0, 32'd0, 64'd11, 11);
        probe_echo(32'd0, 11);
        expect_result("pdis", 5);
        wait_idle("dis_idle", 200);
        check("dis_tx_req", tx_req, 1'b0);

        // Timer stopped: counters freeze, timeout is stretched by the pause.
        enable = 1'b1;
        wait_hs("hs_frz", 10);
        repeat (10) step();
        time_running = 1'b0;
        n0 = seen_results;
        repeat (100) step();
        check("frz_no_result", 64'(seen_results - n0), 64'd0);
        check("frz_busy", busy, 1'b1);
        time_running = 1'b1;
        push(1'b1, 32'd1, 64'd0, 50);
        expect_result("pfrz", 60);
        check("frz_lost_cnt", lost_count, 64'd2);

        // Zero timeout and period behave as 1.
        timeout = 32'd0;
        period = 32'd0;
        wait_hs("hs_zero", 200);
        push(1'b1, 32'd2, 64'd0, 1);
        expect_result("pzero", 5);
        timeout = 32'd200;
        wait_tx_req("zero_period", 10, 2);
        check("zero_lost_cnt", lost_count, 64'd3);

        // Reset in the middle of WAIT_ECHO clears everything, no result.
        wait_hs("hs_rst", 5);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;

        // Latencies 40, 12, 90, then a lost probe.
        foreach (lats[i]) begin
            wait_hs("hs_stat", 10);
            push(1'b0, 32'(i), 64'(lats[i]), lats[i]);
            probe_echo(32'(i), lats[i]);
            expect_result("pstat", 5);
        end
`ifdef ETH_MEASURER_SCHED_STATS_EN
        check("stat_min", lat_min, 64'd12);
        check("stat_max", lat_max, 64'd90);
`endif
        timeout = 32'd5;
        wait_hs("hs_stat_lost", 10);
        push(1'b1, 32'd3, 64'd0, 5);
        expect_result("pstat_lost", 10);
        check("stat_ping", ping_count, 64'd3);
        check("stat_lost_cnt", lost_count, 64'd1);
`ifdef ETH_MEASURER_SCHED_STATS_EN
        check("stat_min_keep", lat_min, 64'd12);
        check("stat_max_keep", lat_max, 64'd90);
`endif

        enable = 1'b0;
        wait_idle("final_idle", 50);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("no_spurious", 64'(seen_results), 64'(popped));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
